// File: rtl/segment_display_mux_if.sv
// Value-load and display-drive signals of the multiplexed 7-segment display controller.
interface segment_display_mux_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 16
);
   logic [WIDTH-1:0]  value_in;
   logic              value_valid;
   logic              hex_mode;
   logic              blank_zero;
   logic [7:0]        seg_out;
   logic [DIGITS-1:0] dig_sel;
   logic              busy;
   logic              overflow;

   modport master (
      output value_in, value_valid, hex_mode, blank_zero,
      input  seg_out, dig_sel, busy, overflow
   );

   modport slave (
      input  value_in, value_valid, hex_mode, blank_zero,
      output seg_out, dig_sel, busy, overflow
   );
endinterface

// File: rtl/segment_display_mux.sv
// Binary value to multiplexed 7-segment display: sequential binary-to-BCD (or hex nibbles),
// double-buffered display register and a free-running digit scanner.
module segment_display_mux #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SCAN_DIV = 1000
) (
   input logic                  clk_in,
   input logic                  rst_n_in,
   segment_display_mux_if.slave bus
);
   // ceil(WIDTH*log10(2))+1; WIDTH*log10(2) is never an integer, so floor+2 is exact.
   localparam int unsigned NBCD  = (WIDTH * 30103) / 100000 + 2;
   localparam int unsigned ACC   = (NBCD > DIGITS) ? NBCD : DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [4*ACC-1:0]    bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hex_q, hex_d;
   logic                blank_q, blank_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic                disp_blank_q, disp_blank_d;
   logic                ovf_q, ovf_d;
   logic [63:0]         hex_wide;

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [DIGITS-1:0]   blank_mask;
   logic                lead;
   logic [3:0]          cur;

   function automatic logic [6:0] font7(input logic [3:0] d);
      unique case (d)
         4'h0: font7 = 7'h3f;
         4'h1: font7 = 7'h06;
         4'h2: font7 = 7'h5b;
         4'h3: font7 = 7'h4f;
         4'h4: font7 = 7'h66;
         4'h5: font7 = 7'h6d;
         4'h6: font7 = 7'h7d;
         4'h7: font7 = 7'h07;
         4'h8: font7 = 7'h7f;
         4'h9: font7 = 7'h6f;
         4'ha: font7 = 7'h77;
         4'hb: font7 = 7'h7c;
         4'hc: font7 = 7'h39;
         4'hd: font7 = 7'h5e;
         4'he: font7 = 7'h79;
         default: font7 = 7'h71;
      endcase
   endfunction

   assign hex_wide = 64'(shift_q);

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bcd_d        = bcd_q;
      bcd_adj      = bcd_q;
      cnt_d        = cnt_q;
      hex_d        = hex_q;
      blank_d      = blank_q;
      disp_d       = disp_q;
      disp_blank_d = disp_blank_q;
      ovf_d        = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.value_valid) begin
               shift_d = bus.value_in;
               hex_d   = bus.hex_mode;
               blank_d = bus.blank_zero;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = bus.hex_mode ? StLoad : StConv;
            end
         end
         StConv: begin
            for (int unsigned i = 0; i < ACC; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            bcd_d   = {bcd_adj[4*ACC-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StLoad;
         end
         StLoad: begin
            if (hex_q) begin
               disp_d = hex_wide[4*DIGITS-1:0];
               ovf_d  = (hex_wide >> (4 * DIGITS)) != '0;
            end else begin
               disp_d = bcd_q[4*DIGITS-1:0];
               ovf_d  = (bcd_q >> (4 * DIGITS)) != '0;
            end
            disp_blank_d = blank_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scanner runs independently of loads so a display update never shifts the scan phase.
   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      lead       = 1'b1;
      blank_mask = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         lead          = lead && (disp_q[4*i +: 4] == 4'd0);
         blank_mask[i] = lead && disp_blank_q;
      end

      cur   = disp_q[{idx_q, 2'b00} +: 4];
      seg_d = {ovf_q && (idx_q == IDX_W'(DIGITS - 1)), font7(cur)};
      if (blank_mask[idx_q]) seg_d = 8'h00;
      sel_d        = '0;
      sel_d[idx_q] = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         hex_q        <= 1'b0;
         blank_q      <= 1'b0;
         disp_q       <= '0;
         disp_blank_q <= 1'b0;
         ovf_q        <= 1'b0;
         pre_q        <= '0;
         idx_q        <= '0;
         seg_q        <= 8'h00;
         sel_q        <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         hex_q        <= hex_d;
         blank_q      <= blank_d;
         disp_q       <= disp_d;
         disp_blank_q <= disp_blank_d;
         ovf_q        <= ovf_d;
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
      end
   end

   assign bus.seg_out  = seg_q;
   assign bus.dig_sel  = sel_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.overflow = ovf_q;
endmodule
